// File: rtl/uart_cmd_controller_if.sv
// uart_cmd_controller_if: UART receive/transmit and sensor handshake bundle for uart_cmd_controller.
interface uart_cmd_controller_if;
  logic       i_Rx_DV;
  logic [7:0] i_Rx_Byte;
  logic       o_Tx_DV;
  logic [7:0] o_Tx_Byte;
  logic       i_Tx_Done;
  logic       o_Sensor_Req;
  logic [7:0] o_Sensor_Cmd;
  logic [4:0] o_Sensor_Addr;
  logic       i_Sensor_Valid;
  logic [7:0] i_Sensor_Data;
  logic       i_Sensor_Err;
  logic       o_Busy;
  modport master (
    input  i_Rx_DV, i_Rx_Byte, i_Tx_Done, i_Sensor_Valid, i_Sensor_Data, i_Sensor_Err,
    output o_Tx_DV, o_Tx_Byte, o_Sensor_Req, o_Sensor_Cmd, o_Sensor_Addr, o_Busy
  );
  modport slave (
    output i_Rx_DV, i_Rx_Byte, i_Tx_Done, i_Sensor_Valid, i_Sensor_Data, i_Sensor_Err,
    input  o_Tx_DV, o_Tx_Byte, o_Sensor_Req, o_Sensor_Cmd, o_Sensor_Addr, o_Busy
  );
endinterface

// File: rtl/uart_cmd_controller.sv
// uart_cmd_controller: assembles two-byte UART commands, issues one sensor request, returns a two-byte response.
module uart_cmd_controller #(
  parameter int NUM_SENSORS  = 32,
  parameter int TIMEOUT_CLKS = 2_500_000
) (
  input logic                   i_Clock,
  input logic                   i_Reset,
  uart_cmd_controller_if.master bus
);
  localparam int CW = TIMEOUT_CLKS > 1 ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);
  typedef enum logic [3:0] {
    IDLE, WAIT_ADDR, CHECK, REQ, WAIT_SENSOR, SEND_B0, WAIT_B0, SEND_B1, WAIT_B1
  } state_e;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    cmd_q, cmd_d, addr_q, addr_d, tx_q, tx_d, b1_q, b1_d;
  logic          cmd_ok, addr_ok, expired;
  assign cmd_ok  = cmd_q inside {8'h03, 8'h04, 8'h05};
  assign addr_ok = int'(addr_q) < NUM_SENSORS;
  assign expired = cnt_q == LAST;
  assign bus.o_Tx_DV       = state_q inside {SEND_B0, SEND_B1};
  assign bus.o_Tx_Byte     = tx_q;
  assign bus.o_Sensor_Req  = state_q == REQ;
  assign bus.o_Sensor_Cmd  = cmd_q;
  assign bus.o_Sensor_Addr = addr_q[4:0];
  assign bus.o_Busy        = state_q != IDLE;
  // Byte 0 is loaded straight into the transmit register; byte 1 waits in b1_q.
  always_comb begin
    state_d = state_q;
    cnt_d   = expired ? cnt_q : cnt_q + 1'b1;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    tx_d    = tx_q;
    b1_d    = b1_q;
    case (state_q)
      IDLE: if (bus.i_Rx_DV) begin
        state_d = WAIT_ADDR;
        cmd_d   = bus.i_Rx_Byte;
        cnt_d   = '0;
      end
      WAIT_ADDR: if (bus.i_Rx_DV) begin
        state_d = CHECK;
        addr_d  = bus.i_Rx_Byte;
      end else if (expired) state_d = IDLE;
      CHECK: begin
        state_d = cmd_ok && addr_ok ? REQ : SEND_B0;
        tx_d    = !cmd_ok ? 8'h1E : !addr_ok ? 8'h1D : tx_q;
        b1_d    = addr_q;
      end
      REQ: begin
        state_d = WAIT_SENSOR;
        cnt_d   = '0;
      end
      WAIT_SENSOR: if (bus.i_Sensor_Valid) begin
        state_d = SEND_B0;
        tx_d    = bus.i_Sensor_Err ? 8'h1F : cmd_q + 8'h05;
        b1_d    = bus.i_Sensor_Err ? addr_q : bus.i_Sensor_Data;
      end else if (expired) begin
        state_d = SEND_B0;
        tx_d    = 8'h1C;
        b1_d    = addr_q;
      end
      SEND_B0: state_d = WAIT_B0;
      WAIT_B0: if (bus.i_Tx_Done) begin
        state_d = SEND_B1;
        tx_d    = b1_q;
      end
      SEND_B1: state_d = WAIT_B1;
      WAIT_B1: if (bus.i_Tx_Done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      tx_q    <= '0;
      b1_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      tx_q    <= tx_d;
      b1_q    <= b1_d;
    end
  end
endmodule

// File: tb/tb_uart_cmd_controller.sv
// tb_uart_cmd_controller: table-driven command transactions with an expected-byte scoreboard plus corner-case sequences.
module tb_uart_cmd_controller;
  localparam int T = 1000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_cmd_controller_if bus();
  uart_cmd_controller #(.NUM_SENSORS(32), .TIMEOUT_CLKS(T)) dut (
    .i_Clock(clk),
    .i_Reset(rst),
    .bus    (bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] cmd;
    logic [7:0] addr;
    bit         req;
    bit         respond;
    int         dly;
    logic [7:0] data;
    bit         err;
    logic [7:0] b0;
    logic [7:0] b1;
  } vec_t;
  vec_t       vecs[8];
  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int req_cnt = 0;
  int tx_cnt = 0;
  always @(posedge clk) begin
    if (bus.o_Sensor_Req) req_cnt++;
    if (bus.o_Tx_DV) tx_cnt++;
  end
  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask
  function automatic bit sig(input int sel);
    return sel == 0 ? bus.o_Tx_DV : sel == 1 ? bus.o_Sensor_Req : !bus.o_Busy;
  endfunction
  task automatic wait_for(input int sel, input int limit, output int n);
    n = 0;
    while (!sig(sel) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!sig(sel)) n = -1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    bus.i_Rx_Byte = b;
    bus.i_Rx_DV = 1'b1;
    @(negedge clk);
    bus.i_Rx_DV = 1'b0;
  endtask
  task automatic sensor_resp(input logic [7:0] d, input bit e);
    bus.i_Sensor_Data = d;
    bus.i_Sensor_Err = e;
    bus.i_Sensor_Valid = 1'b1;
    @(negedge clk);
    bus.i_Sensor_Valid = 1'b0;
  endtask
  task automatic tx_pair(input int lat0, input int limit);
    int n;
    logic [7:0] e;
    string nm;
    for (int k = 0; k < 2; k++) begin
      nm = k == 0 ? "b0" : "b1";
      wait_for(0, k == 0 ? limit : 5, n);
      check({nm, "_lat"}, n, k == 0 ? lat0 : 0);
      if (n < 0) begin
        exp_q.delete();
        return;
      end
      e = exp_q.pop_front();
      check({nm, "_byte"}, bus.o_Tx_Byte, e);
      repeat (4) @(negedge clk);
      check({nm, "_dv_pulse"}, bus.o_Tx_DV, 0);
      check({nm, "_hold"}, bus.o_Tx_Byte, e);
      bus.i_Tx_Done = 1'b1;
      @(negedge clk);
      bus.i_Tx_Done = 1'b0;
    end
    check("busy_end", bus.o_Busy, 0);
  endtask
  task automatic run_vec(input vec_t v);
    int n, r0;
    r0 = req_cnt;
    exp_q.push_back(v.b0);
    exp_q.push_back(v.b1);
    send_byte(v.cmd);
    repeat (3) @(negedge clk);
    check("busy_waddr", bus.o_Busy, 1);
    send_byte(v.addr);
    if (v.req) begin
      wait_for(1, 10, n);
      check("req_lat", n, 1);
      check("req_cmd", bus.o_Sensor_Cmd, v.cmd);
      check("req_addr", bus.o_Sensor_Addr, v.addr[4:0]);
      @(negedge clk);
      check("req_pulse", bus.o_Sensor_Req, 0);
      if (v.respond) begin
        repeat (v.dly) @(negedge clk);
        sensor_resp(v.data, v.err);
        tx_pair(0, 5);
      end else tx_pair(T, T + 50);
    end else tx_pair(1, 10);
    check("req_count", req_cnt - r0, int'(v.req));
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_dv"}, bus.o_Tx_DV, 0);
    check({tag, "_tx_byte"}, bus.o_Tx_Byte, 0);
    check({tag, "_req"}, bus.o_Sensor_Req, 0);
    check({tag, "_cmd"}, bus.o_Sensor_Cmd, 0);
    check({tag, "_addr"}, bus.o_Sensor_Addr, 0);
    check({tag, "_busy"}, bus.o_Busy, 0);
  endtask
  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int n, r0, t0;
    vec_t v;
    vecs[0] = '{8'h04, 8'h02, 1, 1, 20, 8'h19, 0, 8'h09, 8'h19};
    vecs[1] = '{8'h07, 8'h01, 0, 0, 0,  8'h00, 0, 8'h1E, 8'h01};
    vecs[2] = '{8'h03, 8'h20, 0, 0, 0,  8'h00, 0, 8'h1D, 8'h20};
    vecs[3] = '{8'h05, 8'h03, 1, 1, 7,  8'hAA, 1, 8'h1F, 8'h03};
    vecs[4] = '{8'h04, 8'h00, 1, 0, 0,  8'h00, 0, 8'h1C, 8'h00};
    vecs[5] = '{8'h07, 8'h40, 0, 0, 0,  8'h00, 0, 8'h1E, 8'h40};
    vecs[6] = '{8'h03, 8'h1F, 1, 1, 3,  8'h55, 0, 8'h08, 8'h55};
    vecs[7] = '{8'h05, 8'h00, 1, 1, 0,  8'hC3, 0, 8'h0A, 8'hC3};
    bus.i_Rx_DV = 1'b0;
    bus.i_Rx_Byte = 8'h00;
    bus.i_Tx_Done = 1'b0;
    bus.i_Sensor_Valid = 1'b0;
    bus.i_Sensor_Data = 8'h00;
    bus.i_Sensor_Err = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", bus.o_Busy, 0);
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
      repeat (2) @(negedge clk);
    end
    // Sensor result arrives on the very cycle the timeout would fire.
    exp_q.push_back(8'h09);
    exp_q.push_back(8'h77);
    send_byte(8'h04);
    send_byte(8'h01);
    wait_for(1, 10, n);
    check("edge_req_lat", n, 1);
    repeat (T) @(negedge clk);
    sensor_resp(8'h77, 1'b0);
    tx_pair(0, 5);
    repeat (2) @(negedge clk);
    // Lone command byte with no address.
    r0 = req_cnt;
    t0 = tx_cnt;
    send_byte(8'h04);
    check("lone_busy", bus.o_Busy, 1);
    wait_for(2, T + 50, n);
    check("gap_timeout", n, T);
    check("lone_req", req_cnt - r0, 0);
    check("lone_tx", tx_cnt - t0, 0);
    repeat (2) @(negedge clk);
    // Extra bytes while waiting on the sensor.
    r0 = req_cnt;
    exp_q.push_back(8'h09);
    exp_q.push_back(8'h42);
    send_byte(8'h04);
    send_byte(8'h05);
    wait_for(1, 10, n);
    check("extra_req_lat", n, 1);
    @(negedge clk);
    send_byte(8'h03);
    @(negedge clk);
    send_byte(8'h00);
    repeat (5) @(negedge clk);
    sensor_resp(8'h42, 1'b0);
    tx_pair(0, 5);
    repeat (20) @(negedge clk);
    check("extra_dropped_busy", bus.o_Busy, 0);
    check("extra_req_count", req_cnt - r0, 1);
    // Reset while waiting for the first byte to finish.
    send_byte(8'h07);
    send_byte(8'h02);
    wait_for(0, 10, n);
    check("rst_b0_lat", n, 1);
    @(negedge clk);
    check("rst_pre_busy", bus.o_Busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    exp_q.delete();
    bus.i_Tx_Done = 1'b1;
    @(negedge clk);
    bus.i_Tx_Done = 1'b0;
    @(negedge clk);
    check("stale_done_busy", bus.o_Busy, 0);
    check("stale_done_dv", bus.o_Tx_DV, 0);
    v = '{8'h03, 8'h00, 1, 1, 4, 8'h11, 0, 8'h08, 8'h11};
    run_vec(v);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
